// File: rtl/galetron_pkg.sv
// Shared Galetron core definitions: watchdog state encoding, OS/user address
// boundary and the opcodes the reset controller decodes.
package galetron_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } wd_state_e;

  localparam int unsigned OS_LIMIT = 256;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_CTX_JUMP = 4'hC;
  localparam logic [3:0] OP_HALT     = 4'hF;

endpackage

// File: rtl/quantum_watchdog.sv
// Preemption timer: counts retired user-space instructions against the OS
// quantum and holds a context-exchange request until the jump is acknowledged.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | disarmed, output_watchdog reads 0
//   COUNT   | quantum running, user retires decrement counter
//   EXPIRED | quantum exhausted, context_exchange held high
module quantum_watchdog
  import galetron_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned OS_LIMIT    = galetron_pkg::OS_LIMIT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   quantum_load,
  input  logic [COUNT_WIDTH-1:0] quantum_value,
  input  logic                   watchdog_enable,
  input  logic                   instruction_retire,
  input  logic [PC_WIDTH-1:0]    program_counter,
  input  logic                   context_ack,
  output logic [COUNT_WIDTH-1:0] output_watchdog,
  output logic [COUNT_WIDTH-1:0] watchdog_count,
  output logic                   context_exchange
);

  wd_state_e              state, state_nxt;
  logic [COUNT_WIDTH-1:0] quantum_reg, quantum_nxt;
  logic [COUNT_WIDTH-1:0] counter, counter_nxt;
  logic [COUNT_WIDTH-1:0] out_wd_nxt;
  logic                   cx_nxt;
  logic                   zero_load;
  logic                   user_retire;

  assign zero_load   = quantum_load && (quantum_value == '0);
  assign user_retire = instruction_retire &&
                       (program_counter >= PC_WIDTH'(OS_LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      quantum_reg      <= '0;
      counter          <= '0;
      output_watchdog  <= '0;
      context_exchange <= 1'b0;
    end else begin
      state            <= state_nxt;
      quantum_reg      <= quantum_nxt;
      counter          <= counter_nxt;
      output_watchdog  <= out_wd_nxt;
      context_exchange <= cx_nxt;
    end
  end

  // A nonzero load only replaces the stored quantum; the running count keeps
  // going and the new value is picked up on the next arm or reload.
  always_comb begin
    state_nxt   = state;
    quantum_nxt = quantum_reg;
    counter_nxt = counter;
    cx_nxt      = context_exchange;

    if (quantum_load) quantum_nxt = quantum_value;

    if (zero_load) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
      cx_nxt      = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (watchdog_enable && (quantum_reg != '0)) begin
            state_nxt   = COUNT;
            counter_nxt = quantum_reg;
          end
        end
        COUNT: begin
          if (!watchdog_enable) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
          end else if (user_retire && (counter != '0)) begin
            counter_nxt = counter - COUNT_WIDTH'(1);
            if (counter == COUNT_WIDTH'(1)) begin
              state_nxt = EXPIRED;
              cx_nxt    = 1'b1;
            end
          end
        end
        EXPIRED: begin
          if (context_ack) begin
            cx_nxt      = 1'b0;
            counter_nxt = quantum_reg;
            state_nxt   = watchdog_enable ? COUNT : IDLE;
          end else if (!watchdog_enable) begin
            state_nxt = IDLE;
            cx_nxt    = 1'b0;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
          cx_nxt      = 1'b0;
        end
      endcase
    end

    out_wd_nxt = (state_nxt == IDLE) ? '0 : quantum_nxt;
  end

  assign watchdog_count = counter;

endmodule

// File: tb/tb_quantum_watchdog.sv
// Bench for quantum_watchdog: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_quantum_watchdog;

  logic        clock = 1'b0;
  logic        reset;
  logic        quantum_load;
  logic [31:0] quantum_value;
  logic        watchdog_enable;
  logic        instruction_retire;
  logic [11:0] program_counter;
  logic        context_ack;
  logic [31:0] output_watchdog;
  logic [31:0] watchdog_count;
  logic        context_exchange;

  int checks = 0;
  int passed = 0;

  quantum_watchdog #(.COUNT_WIDTH(32), .PC_WIDTH(12), .OS_LIMIT(256)) dut (
    .clock              (clock),
    .reset              (reset),
    .quantum_load       (quantum_load),
    .quantum_value      (quantum_value),
    .watchdog_enable    (watchdog_enable),
    .instruction_retire (instruction_retire),
    .program_counter    (program_counter),
    .context_ack        (context_ack),
    .output_watchdog    (output_watchdog),
    .watchdog_count     (watchdog_count),
    .context_exchange   (context_exchange)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  // Behavioural model: armed / pending flags plus remaining user retires.
  bit          started = 0;
  bit          m_armed, m_pend;
  int unsigned m_q, m_rem;

  always @(posedge clock) begin
    int unsigned q_old;
    bit          user;
    started = 1;
    if (reset) begin
      m_armed = 0; m_pend = 0; m_q = 0; m_rem = 0;
    end else if (quantum_load && quantum_value == 0) begin
      m_armed = 0; m_pend = 0; m_q = 0; m_rem = 0;
    end else begin
      q_old = m_q;
      if (quantum_load) m_q = quantum_value;
      user = instruction_retire && (program_counter >= 12'd256);
      if (!m_armed) begin
        if (watchdog_enable && q_old != 0) begin
          m_armed = 1; m_rem = q_old;
        end
      end else if (!m_pend) begin
        if (!watchdog_enable) begin
          m_armed = 0; m_rem = 0;
        end else if (user && m_rem > 0) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_pend = 1;
        end
      end else begin
        if (context_ack) begin
          m_pend = 0; m_rem = q_old; m_armed = watchdog_enable;
        end else if (!watchdog_enable) begin
          m_armed = 0; m_pend = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("model_output_watchdog", output_watchdog, m_armed ? m_q : 32'd0);
      chk("model_watchdog_count", watchdog_count, m_rem);
      chk("model_context_exchange", {31'd0, context_exchange}, {31'd0, m_pend});
    end
  end

  task automatic drive(input logic rst, input logic ld, input logic [31:0] val,
                       input logic en, input logic ret, input logic [11:0] pc,
                       input logic ak);
    reset = rst; quantum_load = ld; quantum_value = val; watchdog_enable = en;
    instruction_retire = ret; program_counter = pc; context_ack = ak;
    @(negedge clock);
  endtask

  task automatic idle_cyc(input logic en);
    drive(0, 0, 0, en, 0, 0, 0);
  endtask

  task automatic retire(input logic [11:0] pc);
    drive(0, 0, 0, 1, 1, pc, 0);
  endtask

  task automatic load(input logic [31:0] v, input logic en);
    drive(0, 1, v, en, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic en_lvl, ld, ret, ak, rst, en_d;
    logic [31:0] val;
    logic [11:0] pc;

    do_reset();
    do_reset();
    chk("reset_output_watchdog", output_watchdog, 0);
    chk("reset_count", watchdog_count, 0);
    chk("reset_cx", {31'd0, context_exchange}, 0);

    // quantum 5, five user retires
    load(5, 0);
    idle_cyc(1);
    chk("arm_output_watchdog", output_watchdog, 5);
    chk("arm_count", watchdog_count, 5);
    for (int i = 0; i < 4; i++) retire(12'd300);
    chk("q5_before_expiry_count", watchdog_count, 1);
    chk("q5_before_expiry_cx", {31'd0, context_exchange}, 0);
    retire(12'd300);
    chk("q5_expired_cx", {31'd0, context_exchange}, 1);
    chk("q5_expired_count", watchdog_count, 0);
    chk("q5_expired_ow_nonzero", output_watchdog, 5);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("ack_cx", {31'd0, context_exchange}, 0);
    chk("ack_reload", watchdog_count, 5);
    retire(12'd300);
    chk("resume_count", watchdog_count, 4);

    // OS-region retires do not count
    do_reset();
    load(4, 0);
    idle_cyc(1);
    for (int i = 0; i < 3; i++) begin
      retire(12'd100);
      retire(12'd256);
      retire(12'd255);
    end
    chk("os_filter_count", watchdog_count, 1);
    chk("os_filter_cx", {31'd0, context_exchange}, 0);

    // reload mid-quantum applies only after ack
    do_reset();
    load(5, 0);
    idle_cyc(1);
    retire(12'd400);
    retire(12'd400);
    load(10, 1);
    chk("midload_count", watchdog_count, 3);
    chk("midload_ow", output_watchdog, 10);
    for (int i = 0; i < 3; i++) retire(12'd4095);
    chk("midload_expired", {31'd0, context_exchange}, 1);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("midload_ack_count", watchdog_count, 10);

    // enable drop while expired cancels the request
    do_reset();
    load(1, 0);
    idle_cyc(1);
    retire(12'd300);
    chk("q1_expired", {31'd0, context_exchange}, 1);
    idle_cyc(0);
    chk("drop_cx", {31'd0, context_exchange}, 0);
    chk("drop_ow", output_watchdog, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("late_ack_cx", {31'd0, context_exchange}, 0);
    chk("late_ack_count", watchdog_count, 0);

    // reset with request pending
    load(3, 0);
    idle_cyc(1);
    for (int i = 0; i < 3; i++) retire(12'd500);
    chk("pre_reset_cx", {31'd0, context_exchange}, 1);
    do_reset();
    chk("mid_reset_ow", output_watchdog, 0);
    chk("mid_reset_count", watchdog_count, 0);
    chk("mid_reset_cx", {31'd0, context_exchange}, 0);

    // zero-load while armed, and zero-load winning over ack
    load(2, 0);
    idle_cyc(1);
    load(0, 1);
    chk("zero_load_ow", output_watchdog, 0);
    chk("zero_load_count", watchdog_count, 0);
    load(2, 0);
    idle_cyc(1);
    retire(12'd300);
    retire(12'd300);
    chk("pre_race_cx", {31'd0, context_exchange}, 1);
    drive(0, 1, 0, 1, 0, 0, 1);
    chk("race_cx", {31'd0, context_exchange}, 0);
    chk("race_ow", output_watchdog, 0);
    chk("race_count", watchdog_count, 0);

    // randomized traffic
    en_lvl = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      val = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      if ($urandom_range(0, 29) == 0) en_lvl = ~en_lvl;
      en_d = en_lvl;
      ret = $urandom_range(0, 1) == 1;
      pc  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 255))
                                         : 12'($urandom_range(256, 4095));
      ak  = ($urandom_range(0, 7) == 0);
      if (ld && val != 0) begin
        ret = 1'b0;
        ak  = 1'b0;
        if (!m_armed) en_d = 1'b0;
      end
      drive(rst, ld, val, en_d, ret, pc, ak);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
